game_sequencer: RTL
===================

# game_sequencer

Top-level game controller for Space Invaders. It sequences the game through idle, play, win and lose states, and gates the Aliens and Player blocks via `Game_Active`. It arbitrates joystick fire presses into single-cycle `Bullet_Fired` pulses to the Bullet block, applying a per-shot cooldown. It keeps a 4-digit BCD score for the seven-segment display path.

## Interface
Parameters:
- `COOLDOWN_FRAMES`, default 8: frames between accepted shots, range 0–255.
- `END_HOLD_FRAMES`, default 120: frames WIN/LOSE is held before return to IDLE, range 1–255.

Ports:
- `Clk`  in  1  system clock (`DIV_CLK[1]` domain, same as VGA/Bullet).
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  start switch, asynchronous level.
- `Fire_Btn`  in  1  joystick fire button, asynchronous level.
- `Frame_Tick`  in  1  one-`Clk` pulse per video frame, synchronous.
- `Alien_Hit`  in  1  one-cycle pulse from Bullet when an alien is destroyed.
- `Aliens_Defeated`  in  1  level, all aliens cleared.
- `Reached_Bottom`  in  1  level, alien formation reached the player row.
- `Bullet_Onscreen`  in  1  level, a bullet is in flight.
- `Bullet_Fired`  out  1  one-cycle fire request to Bullet.
- `Fire_Ready`  out  1  shot would be accepted now (for LED).
- `Game_Active`  out  1  enables alien march and player motion.
- `Game_State`  out  2  encoding: 00 IDLE, 01 PLAY, 10 WIN, 11 LOSE.
- `Score`  out  16  4 BCD digits, [15:12] thousands.

## Operation
Reset values of all outputs: `Bullet_Fired` 0, `Fire_Ready` 0, `Game_Active` 0, `Game_State` 00, `Score` 0x0000. Internal cooldown and hold counters reset to 0.

Input conditioning:
- `Start` and `Fire_Btn` pass through 2-flop synchronizers.
- Each has one history flop; rising edge = sync high and history low.

State machine:
- IDLE:
  - On `Start` rising edge → PLAY.
  - `Score` is cleared in the same cycle.
  - `Start` already high out of reset does not start a game; it must toggle low then high.
- PLAY:
  - `Game_Active`=1.
  - `Reached_Bottom` → LOSE.
  - `Aliens_Defeated` → WIN.
  - Both high in the same cycle → LOSE.
  - Synchronized `Start` low → IDLE (abort; `Score` retained).
- WIN/LOSE:
  - `Game_Active`=0.
  - On entry, hold counter loads `END_HOLD_FRAMES`; it decrements on each `Frame_Tick`.
  - At 0 with synchronized `Start` low → IDLE.
  - At 0 with `Start` high → stay in WIN/LOSE.

Fire arbitration (PLAY only):
- `Fire_Ready` = PLAY ∧ cooldown==0 ∧ ¬`Bullet_Onscreen`.
- A fire edge with `Fire_Ready`=1 registers `Bullet_Fired`=1 for exactly one cycle and loads cooldown with `COOLDOWN_FRAMES`.
- A fire edge with `Fire_Ready`=0 is dropped, not queued.
- Holding the button does not auto-repeat.
- Cooldown decrements on `Frame_Tick` and saturates at 0.
- Leaving PLAY clears cooldown.
- `COOLDOWN_FRAMES`=0 means the limit is only `Bullet_Onscreen`.

Score:
- `Alien_Hit` while in PLAY increments BCD with carry (0009→0010, 0099→0100).
- Saturates at 9999.
- `Alien_Hit` in the same cycle as the PLAY→WIN/LOSE transition is counted.
- `Alien_Hit` outside PLAY is ignored.

## Timing
- `Fire_Btn` pin → `Bullet_Fired`: 3 `Clk` cycles after the first edge sampling high (2 sync + 1 registered output).
- `Start` → `Game_State`=01: 3 cycles, same path.
- `Alien_Hit`, `Reached_Bottom`, `Aliens_Defeated` are used without synchronization (already in `Clk` domain). Their effect on `Score` / `Game_State` is visible 1 cycle after they are sampled.
- `Game_Active` and `Fire_Ready` are registered and change in the same cycle as `Game_State`.
- `Frame_Tick` in the same cycle as a cooldown load: the load wins.
- Reset asserted mid-game returns all state asynchronously to reset values. Outputs are valid on the first `Clk` edge after release.

## Structure
- Shared package holds the state encodings `GS_IDLE`/`GS_PLAY`/`GS_WIN`/`GS_LOSE` and the BCD digit width. The seven-segment decoder uses the same constants.
- Sub-module `bcd_counter4`: ports `Clk`, `Reset`, `Clear`, `Inc`, `Q[15:0]`; saturating at 9999.
- FSM, synchronizers, cooldown and hold counters live in `game_sequencer`.

## Test plan
- Reset low, then high with `Start`=1 held → `Game_State` stays 00. Drop `Start` and raise it again → `Game_State`=01 after 3 cycles, `Score`=0000, `Game_Active`=1.
- In PLAY with `COOLDOWN_FRAMES`=8, press fire → one `Bullet_Fired` pulse. A second press 3 frames later → no pulse, `Fire_Ready`=0. A press after the 8th `Frame_Tick` → pulse.
- Fire pressed with `Bullet_Onscreen`=1 → no pulse. Releasing `Bullet_Onscreen` does not generate a late pulse.
- 100 `Alien_Hit` pulses in PLAY from 0095 → `Score`=0195. Preload to 9998 plus 3 hits → 9999.
- `Reached_Bottom` and `Aliens_Defeated` asserted in the same cycle → `Game_State`=11, `Game_Active`=0. After 120 `Frame_Tick`s with `Start` low → 00.
- Assert reset mid-PLAY with cooldown at 5 and `Score` 0042 → all outputs at reset values immediately, without a `Clk` edge.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// game_sequencer_pkg : shared game state encodings and score widths
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package game_sequencer_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int SCORE_W     = BCD_DIGIT_W * BCD_DIGITS;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_WIN  = 2'b10,
    GS_LOSE = 2'b11
  } game_state_e;

endpackage

`default_nettype wire

// File: rtl/game_sequencer_bcd_counter4.sv
// ----------------------------------------------------------------------------
// bcd_counter4 : 4-digit BCD up-counter with synchronous clear, saturating at 9999
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bcd_counter4
  import game_sequencer_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Clear,
  input  logic               Inc,
  output logic [SCORE_W-1:0] Q
);

  logic [SCORE_W-1:0] q_q, q_d;
  logic               carry;

  always_comb begin
    q_d   = q_q;
    carry = 1'b0;
    if (Clear) begin
      q_d = '0;
    end else if (Inc && (q_q != SCORE_MAX)) begin
      carry = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (carry) begin
          if (q_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
            q_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
          end else begin
            q_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = q_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer : game FSM, fire arbitration with cooldown, BCD score keeping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int COOLDOWN_FRAMES = 8,
  parameter int END_HOLD_FRAMES = 120
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Fire_Btn,
  input  logic               Frame_Tick,
  input  logic               Alien_Hit,
  input  logic               Aliens_Defeated,
  input  logic               Reached_Bottom,
  input  logic               Bullet_Onscreen,
  output logic               Bullet_Fired,
  output logic               Fire_Ready,
  output logic               Game_Active,
  output logic [1:0]         Game_State,
  output logic [SCORE_W-1:0] Score
);

  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] HOLD_LOAD = 8'(END_HOLD_FRAMES);

  logic [1:0]  start_sync_q, fire_sync_q;
  logic        start_hist_q, fire_hist_q;
  game_state_e state_q, state_d;
  logic [7:0]  cool_q, cool_d;
  logic [7:0]  hold_q, hold_d;
  logic        fire_ready_q, fire_ready_d;
  logic        bullet_fired_q, game_active_q;
  logic        start_lvl, start_rise, fire_rise, shot;
  logic        score_clr, score_inc;

  // Start chain resets high so a switch already on at power-up is not an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      start_sync_q <= 2'b11;
      start_hist_q <= 1'b1;
      fire_sync_q  <= 2'b00;
      fire_hist_q  <= 1'b0;
    end else begin
      start_sync_q <= {start_sync_q[0], Start};
      start_hist_q <= start_sync_q[1];
      fire_sync_q  <= {fire_sync_q[0], Fire_Btn};
      fire_hist_q  <= fire_sync_q[1];
    end
  end

  assign start_lvl  = start_sync_q[1];
  assign start_rise = start_sync_q[1] & ~start_hist_q;
  assign fire_rise  = fire_sync_q[1] & ~fire_hist_q;

  always_comb begin
    state_d   = state_q;
    score_clr = 1'b0;
    unique case (state_q)
      GS_IDLE: begin
        if (start_rise) begin
          state_d   = GS_PLAY;
          score_clr = 1'b1;
        end
      end
      GS_PLAY: begin
        if (Reached_Bottom)       state_d = GS_LOSE;
        else if (Aliens_Defeated) state_d = GS_WIN;
        else if (!start_lvl)      state_d = GS_IDLE;
      end
      default: begin
        if ((hold_q == 8'd0) && !start_lvl) state_d = GS_IDLE;
      end
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if ((state_q == GS_PLAY) && ((state_d == GS_WIN) || (state_d == GS_LOSE))) begin
      hold_d = HOLD_LOAD;
    end else if (Frame_Tick && (hold_q != 8'd0)) begin
      hold_d = hold_q - 8'd1;
    end
  end

  // A shot is judged against the readiness shown on the LED this cycle.
  assign shot      = fire_rise & fire_ready_q;
  assign score_inc = Alien_Hit & (state_q == GS_PLAY);

  always_comb begin
    cool_d = cool_q;
    if (state_d != GS_PLAY) begin
      cool_d = 8'd0;
    end else if (shot) begin
      cool_d = COOL_LOAD;
    end else if (Frame_Tick && (cool_q != 8'd0)) begin
      cool_d = cool_q - 8'd1;
    end
    fire_ready_d = (state_d == GS_PLAY) && (cool_d == 8'd0) && !Bullet_Onscreen;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= GS_IDLE;
      hold_q         <= 8'd0;
      cool_q         <= 8'd0;
      fire_ready_q   <= 1'b0;
      bullet_fired_q <= 1'b0;
      game_active_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      cool_q         <= cool_d;
      fire_ready_q   <= fire_ready_d;
      bullet_fired_q <= shot;
      game_active_q  <= (state_d == GS_PLAY);
    end
  end

  bcd_counter4 u_score (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (score_clr),
    .Inc   (score_inc),
    .Q     (Score)
  );

  assign Game_State   = state_q;
  assign Game_Active  = game_active_q;
  assign Fire_Ready   = fire_ready_q;
  assign Bullet_Fired = bullet_fired_q;

endmodule

`default_nettype wire
